// File: rtl/if_fetch_unit.sv
// Instruction fetch front end: in-order imem req/gnt/rvalid, DEPTH-entry {pc,instr,fault} buffer to IF/ID.
// Response-to-instr_valid_o latency 1 cycle; holds the PC (fetch_stall_o) when buffer+outstanding is full.
module if_fetch_unit #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_i,
    input  logic        flush_i,
    output logic [31:0] pre_pc_o,
    output logic        fetch_stall_o,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_fault_o,
    output logic        proto_err_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } entry_t;

    state_t          state_q;
    entry_t          fifo_q [DEPTH];
    logic [31:0]     pend_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q, pend_wr_q, pend_rd_q;
    logic [CW-1:0]   count_q, outst_q, discard_q;
    logic            proto_err_q;

    logic            room, aligned, run_ok, acc_mem, fault_push, accepted;
    logic            rv_ok, rv_drop, resp_push, push, pop;
    logic [CW-1:0]   outst_d, discard_left;
    entry_t          push_ent, head;

    assign room       = ({1'b0, count_q} + {1'b0, outst_q}) < (CW+1)'(DEPTH);
    assign aligned    = (pc_i[1:0] == 2'b00);
    assign run_ok     = (state_q == S_RUN) && !flush_i && room;
    assign imem_req_o = run_ok && aligned;
    assign acc_mem    = imem_req_o && imem_gnt_i;
    // Misaligned fault entries wait until older fetches have returned, so order is kept.
    assign fault_push = run_ok && !aligned && (outst_q == '0);
    assign accepted   = acc_mem || fault_push;

    assign rv_ok        = imem_rvalid_i && (outst_q != '0);
    assign rv_drop      = rv_ok && (discard_q != '0);
    assign resp_push    = rv_ok && !rv_drop;
    assign push         = resp_push || fault_push;
    assign pop          = instr_valid_o && instr_ready_i;
    assign outst_d      = outst_q + CW'(acc_mem) - CW'(rv_ok);
    assign discard_left = discard_q - CW'(rv_drop);

    assign push_ent = fault_push ? '{pc: pc_i, instr: NOP, fault: 1'b1}
                                 : '{pc: pend_q[pend_rd_q], instr: imem_rdata_i, fault: 1'b0};
    assign head     = fifo_q[rd_ptr_q];

    assign pre_pc_o      = pc_i + 32'd4;
    assign imem_addr_o   = pc_i;
    assign fetch_stall_o = !flush_i && !accepted;
    assign instr_valid_o = (count_q != '0);
    assign instr_o       = instr_valid_o ? head.instr : 32'h0;
    assign instr_pc_o    = instr_valid_o ? head.pc    : RESET_PC;
    assign instr_fault_o = instr_valid_o && head.fault;
    assign proto_err_o   = proto_err_q;

    always_ff @(posedge clk) begin
        if (push && !flush_i) begin
            fifo_q[wr_ptr_q] <= push_ent;
        end
        if (acc_mem) begin
            pend_q[pend_wr_q] <= pc_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            pend_wr_q   <= '0;
            pend_rd_q   <= '0;
            count_q     <= '0;
            outst_q     <= '0;
            discard_q   <= '0;
            proto_err_q <= 1'b0;
        end else begin
            outst_q <= outst_d;
            if (acc_mem) pend_wr_q <= pend_wr_q + 1'b1;
            if (rv_ok)   pend_rd_q <= pend_rd_q + 1'b1;
            if (imem_rvalid_i && (outst_q == '0)) proto_err_q <= 1'b1;

            if (flush_i) begin
                count_q   <= '0;
                wr_ptr_q  <= '0;
                rd_ptr_q  <= '0;
                discard_q <= outst_d;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
                count_q   <= count_q + CW'(push) - CW'(pop);
                discard_q <= discard_left;
            end

            case (state_q)
                S_IDLE:  state_q <= S_RUN;
                S_RUN:   if (flush_i && (outst_d != '0)) state_q <= S_DRAIN;
                S_DRAIN: begin
                    if (flush_i) state_q <= (outst_d != '0) ? S_DRAIN : S_RUN;
                    else if (discard_left == '0) state_q <= S_RUN;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed vectors and sequences, then a random run checked against
// the architectural program-order instruction stream.
module tb_if_fetch_unit;
    localparam int DEPTH = 2;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_i;
    logic        flush_i;
    logic [31:0] pre_pc_o;
    logic        fetch_stall_o;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_fault_o;
    logic        proto_err_o;

    int errors = 0;
    int checks = 0;

    if_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset), .pc_i(pc_i), .flush_i(flush_i), .pre_pc_o(pre_pc_o),
        .fetch_stall_o(fetch_stall_o), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i), .instr_o(instr_o),
        .instr_pc_o(instr_pc_o), .instr_fault_o(instr_fault_o), .proto_err_o(proto_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        fl;
        logic [31:0] exp_pre;
        logic        exp_req;
        logic        exp_stall;
    } vec_t;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
    endfunction

    task automatic chk32(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h want=%h", nm, got, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%b want=%b", nm, got, exp);
        end
    endtask

    // Called just after a falling edge; outputs are settled on return.
    task automatic setin(input logic [31:0] pc, input logic fl, input logic gn, input logic rv,
                         input logic [31:0] rd, input logic rdy);
        pc_i = pc; flush_i = fl; imem_gnt_i = gn; imem_rvalid_i = rv;
        imem_rdata_i = rd; instr_ready_i = rdy;
        #1;
    endtask

    task automatic chk_reset_outs(input string nm);
        chk1({nm, "_req"}, imem_req_o, 1'b0);
        chk1({nm, "_valid"}, instr_valid_o, 1'b0);
        chk32({nm, "_instr"}, instr_o, 32'h0);
        chk32({nm, "_ipc"}, instr_pc_o, 32'h0);
        chk1({nm, "_fault"}, instr_fault_o, 1'b0);
        chk1({nm, "_proto"}, proto_err_o, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        setin(32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk_reset_outs("reset");
        reset = 1'b1;
    endtask

    localparam logic [31:0] RD0  = 32'h0050_0093;
    localparam logic [31:0] RD4  = 32'h00A0_0113;
    localparam logic [31:0] RD8  = 32'h0010_8093;
    localparam logic [31:0] RDC  = 32'h0020_8093;
    localparam logic [31:0] RD40 = 32'h0030_8093;

    vec_t        vt [8];
    logic [31:0] pend [$];
    logic [31:0] rpc, exp_next, tgt, rd;
    logic        fl, gn, rv, rdy, fexp;
    int          delivered;

    initial begin
        vt[0] = '{32'h0000_0100, 1'b0, 32'h0000_0104, 1'b1, 1'b1};
        vt[1] = '{32'h0000_0104, 1'b0, 32'h0000_0108, 1'b1, 1'b1};
        vt[2] = '{32'h0000_0007, 1'b0, 32'h0000_000B, 1'b0, 1'b0};
        vt[3] = '{32'hFFFF_FFFC, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        vt[4] = '{32'h0000_0002, 1'b0, 32'h0000_0006, 1'b0, 1'b0};
        vt[5] = '{32'h0000_0200, 1'b1, 32'h0000_0204, 1'b0, 1'b0};
        vt[6] = '{32'hFFFF_FFFD, 1'b0, 32'h0000_0001, 1'b0, 1'b0};
        vt[7] = '{32'h8000_0000, 1'b0, 32'h8000_0004, 1'b1, 1'b1};

        do_reset();

        // Basic fetch: idle cycle, request, response, delivery one cycle later.
        setin(32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk1("t1_idle_stall", fetch_stall_o, 1'b1);
        chk1("t1_idle_req", imem_req_o, 1'b0);
        chk32("t1_pre_pc", pre_pc_o, 32'h4);
        @(negedge clk);
        setin(32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk1("t1_req", imem_req_o, 1'b1);
        chk32("t1_addr", imem_addr_o, 32'h0);
        chk1("t1_run_stall", fetch_stall_o, 1'b0);
        @(negedge clk);
        setin(32'h4, 1'b0, 1'b0, 1'b1, RD0, 1'b0);
        chk1("t1_no_bypass", instr_valid_o, 1'b0);
        @(negedge clk);

        // Grant withheld: address and stall hold while the first entry waits.
        for (int i = 0; i < 3; i++) begin
            setin(32'h4, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
            chk32("t5_addr_hold", imem_addr_o, 32'h4);
            chk1("t5_req_hold", imem_req_o, 1'b1);
            chk1("t5_stall", fetch_stall_o, 1'b1);
            if (i == 0) begin
                chk1("t1_valid", instr_valid_o, 1'b1);
                chk32("t1_instr_pc", instr_pc_o, 32'h0);
                chk32("t1_instr", instr_o, RD0);
            end
            @(negedge clk);
        end

        // Capacity: one buffered + one outstanding fills DEPTH=2.
        setin(32'h4, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk1("t2_req2", imem_req_o, 1'b1);
        @(negedge clk);
        setin(32'h8, 1'b0, 1'b1, 1'b1, RD4, 1'b0);
        chk1("t2_full_req", imem_req_o, 1'b0);
        chk1("t2_full_stall", fetch_stall_o, 1'b1);
        @(negedge clk);
        setin(32'h8, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        chk32("t2_pop0_pc", instr_pc_o, 32'h0);
        chk1("t2_full_req2", imem_req_o, 1'b0);
        @(negedge clk);
        setin(32'h8, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk32("t2_pop1_pc", instr_pc_o, 32'h4);
        chk32("t2_pop1_instr", instr_o, RD4);
        @(negedge clk);

        // Redirect with two fetches in flight: both responses dropped.
        setin(32'h8, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        setin(32'hC, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk1("t3_req_c", imem_req_o, 1'b1);
        @(negedge clk);
        setin(32'h10, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        chk1("t3_flush_req", imem_req_o, 1'b0);
        chk1("t3_flush_stall", fetch_stall_o, 1'b0);
        @(negedge clk);
        setin(32'h40, 1'b0, 1'b1, 1'b1, RD8, 1'b0);
        chk1("t3_drain_req", imem_req_o, 1'b0);
        chk1("t3_drain_stall", fetch_stall_o, 1'b1);
        @(negedge clk);
        setin(32'h40, 1'b0, 1'b1, 1'b1, RDC, 1'b0);
        chk1("t3_drain_req2", imem_req_o, 1'b0);
        @(negedge clk);
        setin(32'h40, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk1("t3_req_40", imem_req_o, 1'b1);
        chk1("t3_no_wrong_path", instr_valid_o, 1'b0);
        @(negedge clk);
        setin(32'h44, 1'b0, 1'b0, 1'b1, RD40, 1'b0);
        chk1("t3_no_wrong_path2", instr_valid_o, 1'b0);
        @(negedge clk);
        setin(32'h44, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk32("t3_first_pc", instr_pc_o, 32'h40);
        chk32("t3_first_instr", instr_o, RD40);
        @(negedge clk);

        // Misaligned PC becomes a fault entry without a memory request.
        setin(32'h6, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk1("t4_no_req", imem_req_o, 1'b0);
        chk1("t4_stall", fetch_stall_o, 1'b0);
        @(negedge clk);
        setin(32'h8, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk1("t4_valid", instr_valid_o, 1'b1);
        chk1("t4_fault", instr_fault_o, 1'b1);
        chk32("t4_instr", instr_o, NOP);
        chk32("t4_pc", instr_pc_o, 32'h6);
        @(negedge clk);
        setin(32'h8, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        @(negedge clk);
        setin(32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk32("t5_pre_pc_wrap", pre_pc_o, 32'h0);
        @(negedge clk);

        // Stray response, then reset in the middle of a fetch.
        setin(32'h8, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        chk1("t6_proto_before", proto_err_o, 1'b0);
        @(negedge clk);
        setin(32'h8, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk1("t6_proto_set", proto_err_o, 1'b1);
        chk1("t6_fifo_unchanged", instr_valid_o, 1'b0);
        @(negedge clk);
        setin(32'h8, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        setin(32'hC, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk1("t6_proto_sticky", proto_err_o, 1'b1);
        reset = 1'b0;
        @(negedge clk);
        setin(32'hC, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk_reset_outs("t6_midreset");
        reset = 1'b1;
        @(negedge clk);

        // Vector table, applied in S_RUN with no grants and the consumer always ready.
        for (int i = 0; i < 8; i++) begin
            setin(vt[i].pc, vt[i].fl, 1'b0, 1'b0, 32'h0, 1'b1);
            chk32($sformatf("vec%0d_pre_pc", i), pre_pc_o, vt[i].exp_pre);
            chk1($sformatf("vec%0d_req", i), imem_req_o, vt[i].exp_req);
            chk1($sformatf("vec%0d_stall", i), fetch_stall_o, vt[i].exp_stall);
            @(negedge clk);
        end

        // Random run: delivered entries must follow program order from the last redirect.
        do_reset();
        rpc       = 32'h0000_1000;
        exp_next  = rpc;
        delivered = 0;
        pend.delete();
        for (int c = 0; c < 3000; c++) begin
            fl  = ($urandom_range(0, 24) == 0);
            tgt = $urandom & 32'h0000_3FFC;
            if ($urandom_range(0, 7) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
            gn  = ($urandom_range(0, 3) != 0);
            rv  = (pend.size() > 0) && ($urandom_range(0, 2) != 0);
            rd  = rv ? mem_word(pend[0]) : $urandom;
            rdy = ($urandom_range(0, 4) < 3);
            setin(rpc, fl, gn, rv, rd, rdy);

            chk32("rnd_pre_pc", pre_pc_o, rpc + 32'd4);
            if (imem_req_o) chk32("rnd_addr", imem_addr_o, rpc);
            if (fl) chk1("rnd_flush_free", imem_req_o || fetch_stall_o, 1'b0);
            if (!fl && !fetch_stall_o)
                chk1("rnd_accept_reason", (imem_req_o && gn) || (rpc[1:0] != 2'b00), 1'b1);
            if (instr_valid_o && rdy && !fl) begin
                fexp = (exp_next[1:0] != 2'b00);
                chk32("rnd_deliver_pc", instr_pc_o, exp_next);
                chk32("rnd_deliver_instr", instr_o, fexp ? NOP : mem_word(exp_next));
                chk1("rnd_deliver_fault", instr_fault_o, fexp);
                exp_next  = exp_next + 32'd4;
                delivered++;
            end

            if (rv) void'(pend.pop_front());
            if (imem_req_o && gn) pend.push_back(rpc);
            chk1("rnd_outstanding_cap", pend.size() <= DEPTH, 1'b1);
            if (fl) begin
                rpc      = tgt;
                exp_next = tgt;
            end else if (!fetch_stall_o) begin
                rpc = rpc + 32'd4;
            end
            @(negedge clk);
        end
        chk1("rnd_liveness", delivered > 200, 1'b1);
        chk1("rnd_proto_clean", proto_err_o, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
